uart_txsched: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baudgen.sv | 36 +++
 rtl/uart_txsched.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings and round-robin pick helper
package uart_pkg;

  localparam int MAXREQ = 8;
  localparam int PTRW   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SENT = 2'b01,
    BUSY = 2'b10
  } tx_state_e;

  // One-hot of the first set req bit after ptr, wrapping modulo n (n <= MAXREQ).
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] req,
                                                input logic [PTRW-1:0]   ptr,
                                                input int                n);
    logic [MAXREQ-1:0] pick;
    int idx;
    pick = '0;
    for (int k = 1; k <= MAXREQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k <= n && pick == '0 && req[idx[PTRW-1:0]]) pick[idx[PTRW-1:0]] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_baudgen.sv
// rtl/uart_baudgen.sv - programmable divider producing the one-cycle bitxce strobe
module uart_baudgen #(
  parameter int DIVW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [DIVW-1:0] divisor,
  output logic            bitxce
);

  logic [DIVW-1:0] divcnt_q, divcnt_d;
  logic            bitxce_q, bitxce_d;

  // divisor is only sampled on reload, so a change never shortens the running period
  always_comb begin
    divcnt_d = divcnt_q - DIVW'(1);
    bitxce_d = 1'b0;
    if (divcnt_q == '0) begin
      divcnt_d = divisor;
      bitxce_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      divcnt_q <= '0;
      bitxce_q <= 1'b0;
    end else begin
      divcnt_q <= divcnt_d;
      bitxce_q <= bitxce_d;
    end
  end

  assign bitxce = bitxce_q;

endmodule

// File: rtl/uart_txsched.sv
// rtl/uart_txsched.sv - round-robin/lockable sharing of one UART transmitter among NREQ requesters
module uart_txsched
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DIVW = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DIVW-1:0]   divisor,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [8*NREQ-1:0] dreq,
  input  logic              txbusy,
  output logic              bitxce,
  output logic              load,
  output logic [7:0]        d,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   gnt
);

  tx_state_e         state_q, state_d;
  logic              load_q, load_d;
  logic [7:0]        d_q, d_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [MAXREQ-1:0] req_w, cand;
  logic [NREQ-1:0]   sel_oh;
  logic              owner_locked, found;
  int                sel;

  uart_baudgen #(.DIVW(DIVW)) u_baudgen (
    .clk     (clk),
    .rstn    (rstn),
    .divisor (divisor),
    .bitxce  (bitxce)
  );

  always_comb begin
    req_w = '0;
    req_w[NREQ-1:0] = req;
    owner_locked = |(gnt_q & lock);
    cand = '0;
    // A locked owner excludes everyone else, even when it has nothing to send.
    if (owner_locked) cand[NREQ-1:0] = gnt_q & req;
    else              cand = rr_pick(req_w, ptr_q, NREQ);
    found = 1'b0;
    sel   = 0;
    for (int i = 0; i < MAXREQ; i++) begin
      if (cand[i] && !found) begin
        found = 1'b1;
        sel   = i;
      end
    end
    sel_oh = NREQ'(1) << sel;

    state_d = state_q;
    load_d  = 1'b0;
    ack_d   = '0;
    d_d     = d_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (!txbusy) begin
          if (!owner_locked) gnt_d = '0;
          if (found) begin
            load_d  = 1'b1;
            ack_d   = sel_oh;
            gnt_d   = sel_oh;
            ptr_d   = PTRW'(sel);
            state_d = SENT;
            for (int i = 0; i < NREQ; i++) begin
              if (i == sel) d_d = dreq[8*i +: 8];
            end
          end
        end
      end
      SENT:    state_d = BUSY;
      BUSY:    if (!txbusy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      d_q     <= 8'h00;
      ack_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= PTRW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      d_q     <= d_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign load = load_q;
  assign d    = d_q;
  assign ack  = ack_q;
  assign gnt  = gnt_q;

endmodule
